// File: rtl/core_pipe_exec_lsu_split_if.sv
// Execute-stage LSU bundle: core request/response channel plus data-memory bus.
// master = core/memory side, slave = the LSU.
interface core_pipe_exec_lsu_split_if #(
  parameter int XLEN       = 64,
  parameter int MEM_DATA_W = 64
);
  localparam int B = MEM_DATA_W / 8;

  logic                  in_valid, in_ready;
  logic [XLEN-1:0]       in_addr, in_wdata;
  logic                  in_load, in_store, in_sext;
  logic [1:0]            in_size;
  logic                  rsp_valid, rsp_trap_bus, rsp_trap_addr;
  logic [XLEN-1:0]       rsp_rdata;
  logic                  dmem_req, dmem_wen, dmem_gnt, dmem_err;
  logic [XLEN-1:0]       dmem_addr;
  logic [B-1:0]          dmem_strb;
  logic [MEM_DATA_W-1:0] dmem_wdata, dmem_rdata;

  modport master (
    output in_valid, in_addr, in_wdata, in_load, in_store, in_size, in_sext,
    input  in_ready, rsp_valid, rsp_rdata, rsp_trap_bus, rsp_trap_addr,
    input  dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
    output dmem_gnt, dmem_err, dmem_rdata
  );

  modport slave (
    input  in_valid, in_addr, in_wdata, in_load, in_store, in_size, in_sext,
    output in_ready, rsp_valid, rsp_rdata, rsp_trap_bus, rsp_trap_addr,
    output dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
    input  dmem_gnt, dmem_err, dmem_rdata
  );
endinterface

// File: rtl/core_pipe_exec_lsu_split.sv
// Execute-stage load/store unit: splits bus-word-crossing accesses into two
// beats, merges and extends read data, one registered response per access.
module core_pipe_exec_lsu_split #(
  parameter int XLEN        = 64,
  parameter int MEM_DATA_W  = 64,
  parameter int MISALIGN_EN = 1
) (
  input  logic g_clk,
  input  logic g_rst,
  core_pipe_exec_lsu_split_if.slave bus
);
  localparam int B  = MEM_DATA_W / 8;
  localparam int OW = $clog2(B);
  localparam int MW = $clog2(MEM_DATA_W);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            store;
    logic [1:0]      size;
    logic            sext;
    logic            split;
  } req_t;

  state_t                state, state_nx;
  req_t                  req_q;
  logic                  trap_bus_q, trap_addr_q;
  logic [MEM_DATA_W-1:0] rd0_q, rd1_q;

  logic       hs, in_split, in_mis, in_big, in_bad, align_err;
  logic [3:0] in_nbytes;
  logic [4:0] in_end;
  assign hs        = bus.in_valid && (state == IDLE);
  assign in_nbytes = 4'd1 << bus.in_size;
  assign in_end    = 5'(bus.in_addr[OW-1:0]) + 5'(in_nbytes);
  assign in_split  = in_end > 5'(B);
  assign in_mis    = (bus.in_addr[2:0] & 3'(in_nbytes - 4'd1)) != 3'd0;
  assign in_big    = 5'(in_nbytes) > 5'(B);
  assign in_bad    = (XLEN == 32) && (bus.in_size == 2'd3);
  assign align_err = in_bad || (in_mis && (MISALIGN_EN == 0 || in_big));

  // Beat 1 strobes/data are simply the spill-over half of a double-width shift.
  logic [OW-1:0]           off;
  logic [XLEN-1:0]         addr0, addr1;
  logic [3:0]              nbytes;
  logic [15:0]             strb_w;
  logic [2*MEM_DATA_W-1:0] wd_w;
  assign off    = req_q.addr[OW-1:0];
  assign addr0  = {req_q.addr[XLEN-1:OW], {OW{1'b0}}};
  assign addr1  = addr0 + XLEN'(B);
  assign nbytes = 4'd1 << req_q.size;
  assign strb_w = ((16'd1 << nbytes) - 16'd1) << off;
  assign wd_w   = {{(2*MEM_DATA_W-XLEN){1'b0}}, req_q.wdata} << {off, 3'b000};

  logic [OW+3:0]         sh_hi;
  logic [MEM_DATA_W-1:0] merged;
  logic [6:0]            nbits;
  logic [XLEN-1:0]       keep, ext;
  logic                  sign;
  assign sh_hi  = {(OW+1)'(B) - {1'b0, off}, 3'b000};
  assign merged = (rd0_q >> {off, 3'b000}) | (req_q.split ? rd1_q << sh_hi : '0);
  assign nbits  = 7'd8 << req_q.size;
  assign keep   = (int'(nbits) >= XLEN) ? '1 : (XLEN'(1) << nbits) - XLEN'(1);
  assign sign   = req_q.sext && merged[MW'(nbits - 7'd1)];
  assign ext    = (merged[XLEN-1:0] & keep) | (sign ? ~keep : '0);

  always_ff @(posedge g_clk) begin
    if (g_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hs) state_nx = align_err ? RESP : BEAT0;
      BEAT0:   if (bus.dmem_gnt) state_nx = (bus.dmem_err || !req_q.split) ? RESP : BEAT1;
      BEAT1:   if (bus.dmem_gnt) state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      req_q       <= '0;
      trap_bus_q  <= 1'b0;
      trap_addr_q <= 1'b0;
      rd0_q       <= '0;
      rd1_q       <= '0;
    end else begin
      if (hs) begin
        req_q <= '{addr: bus.in_addr, wdata: bus.in_wdata, store: bus.in_store & ~bus.in_load,
                   size: bus.in_size, sext: bus.in_sext, split: in_split};
        trap_addr_q <= align_err;
        trap_bus_q  <= 1'b0;
      end
      if (state == BEAT0 && bus.dmem_gnt) begin
        rd0_q      <= bus.dmem_rdata;
        trap_bus_q <= bus.dmem_err;
      end
      if (state == BEAT1 && bus.dmem_gnt) begin
        rd1_q      <= bus.dmem_rdata;
        trap_bus_q <= trap_bus_q | bus.dmem_err;
      end
    end
  end

  // Bus fields come only from latched state, so they hold steady through stalls.
  always_comb begin
    bus.in_ready      = (state == IDLE);
    bus.rsp_valid     = (state == RESP);
    bus.rsp_trap_bus  = (state == RESP) && trap_bus_q;
    bus.rsp_trap_addr = (state == RESP) && trap_addr_q;
    bus.rsp_rdata     = (state == RESP && !req_q.store && !trap_bus_q && !trap_addr_q) ? ext : '0;
    bus.dmem_req      = 1'b0;
    bus.dmem_addr     = '0;
    bus.dmem_wen      = 1'b0;
    bus.dmem_strb     = '0;
    bus.dmem_wdata    = '0;
    case (state)
      BEAT0: begin
        bus.dmem_req   = 1'b1;
        bus.dmem_addr  = addr0;
        bus.dmem_wen   = req_q.store;
        bus.dmem_strb  = strb_w[B-1:0];
        bus.dmem_wdata = wd_w[MEM_DATA_W-1:0];
      end
      BEAT1: begin
        bus.dmem_req   = 1'b1;
        bus.dmem_addr  = addr1;
        bus.dmem_wen   = req_q.store;
        bus.dmem_strb  = strb_w[2*B-1:B];
        bus.dmem_wdata = wd_w[2*MEM_DATA_W-1:MEM_DATA_W];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_core_pipe_exec_lsu_split.sv
// Bench for core_pipe_exec_lsu_split: three configurations (64/64 split, 64/64 strict,
// 32/32 split), table vectors, reset corner sequences, random accesses vs byte model.
module tb_core_pipe_exec_lsu_split;
  logic g_clk = 1'b0, g_rst = 1'b1;
  always #5 g_clk = ~g_clk;

  logic        v[3], g[3];
  logic [63:0] i_addr, i_wdata, i_rdata;
  logic        i_load, i_store, i_sext, i_err;
  logic [1:0]  i_size;
  logic        o_ready[3], o_rv[3], o_tb[3], o_ta[3], o_req[3], o_wen[3];
  logic [63:0] o_rdata[3], o_addr[3], o_wdata[3];
  logic [7:0]  o_strb[3];

  core_pipe_exec_lsu_split_if #(.XLEN(64), .MEM_DATA_W(64)) if0 ();
  core_pipe_exec_lsu_split_if #(.XLEN(64), .MEM_DATA_W(64)) if1 ();
  core_pipe_exec_lsu_split_if #(.XLEN(32), .MEM_DATA_W(32)) if2 ();

  core_pipe_exec_lsu_split #(.XLEN(64), .MEM_DATA_W(64), .MISALIGN_EN(1)) dut0 (.g_clk(g_clk), .g_rst(g_rst), .bus(if0.slave));
  core_pipe_exec_lsu_split #(.XLEN(64), .MEM_DATA_W(64), .MISALIGN_EN(0)) dut1 (.g_clk(g_clk), .g_rst(g_rst), .bus(if1.slave));
  core_pipe_exec_lsu_split #(.XLEN(32), .MEM_DATA_W(32), .MISALIGN_EN(1)) dut2 (.g_clk(g_clk), .g_rst(g_rst), .bus(if2.slave));

  assign if0.in_valid = v[0]; assign if0.in_addr = i_addr; assign if0.in_wdata = i_wdata;
  assign if0.in_load = i_load; assign if0.in_store = i_store; assign if0.in_size = i_size;
  assign if0.in_sext = i_sext; assign if0.dmem_gnt = g[0]; assign if0.dmem_err = i_err;
  assign if0.dmem_rdata = i_rdata;
  assign if1.in_valid = v[1]; assign if1.in_addr = i_addr; assign if1.in_wdata = i_wdata;
  assign if1.in_load = i_load; assign if1.in_store = i_store; assign if1.in_size = i_size;
  assign if1.in_sext = i_sext; assign if1.dmem_gnt = g[1]; assign if1.dmem_err = i_err;
  assign if1.dmem_rdata = i_rdata;
  assign if2.in_valid = v[2]; assign if2.in_addr = i_addr[31:0]; assign if2.in_wdata = i_wdata[31:0];
  assign if2.in_load = i_load; assign if2.in_store = i_store; assign if2.in_size = i_size;
  assign if2.in_sext = i_sext; assign if2.dmem_gnt = g[2]; assign if2.dmem_err = i_err;
  assign if2.dmem_rdata = i_rdata[31:0];

  assign o_ready[0] = if0.in_ready; assign o_rv[0] = if0.rsp_valid; assign o_tb[0] = if0.rsp_trap_bus;
  assign o_ta[0] = if0.rsp_trap_addr; assign o_req[0] = if0.dmem_req; assign o_wen[0] = if0.dmem_wen;
  assign o_rdata[0] = if0.rsp_rdata; assign o_addr[0] = if0.dmem_addr; assign o_wdata[0] = if0.dmem_wdata;
  assign o_strb[0] = if0.dmem_strb;
  assign o_ready[1] = if1.in_ready; assign o_rv[1] = if1.rsp_valid; assign o_tb[1] = if1.rsp_trap_bus;
  assign o_ta[1] = if1.rsp_trap_addr; assign o_req[1] = if1.dmem_req; assign o_wen[1] = if1.dmem_wen;
  assign o_rdata[1] = if1.rsp_rdata; assign o_addr[1] = if1.dmem_addr; assign o_wdata[1] = if1.dmem_wdata;
  assign o_strb[1] = if1.dmem_strb;
  assign o_ready[2] = if2.in_ready; assign o_rv[2] = if2.rsp_valid; assign o_tb[2] = if2.rsp_trap_bus;
  assign o_ta[2] = if2.rsp_trap_addr; assign o_req[2] = if2.dmem_req; assign o_wen[2] = if2.dmem_wen;
  assign o_rdata[2] = 64'(if2.rsp_rdata); assign o_addr[2] = 64'(if2.dmem_addr);
  assign o_wdata[2] = 64'(if2.dmem_wdata); assign o_strb[2] = 8'(if2.dmem_strb);

  typedef struct {
    logic [63:0] addr, wdata, rd0, rd1;
    bit          load, sext, err0, err1;
    int          size, stall;
  } acc_t;
  typedef struct {
    bit          ta, tb;
    logic [63:0] rdata;
    int          nbeats;
    logic [63:0] baddr[2], wd[2];
    logic [7:0]  strb[2];
  } exp_t;
  typedef struct {
    logic [63:0] rdata;
    logic        tb, ta;
    logic [7:0]  s0, s1;
    int          cyc;
  } res_t;
  typedef struct {
    int          k;
    acc_t        a;
    logic [63:0] rdata;
    bit          tb, ta;
    logic [7:0]  s0, s1;
    int          cyc;
  } vec_t;

  int   total = 0, bad = 0;
  vec_t tbl[$];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  function automatic logic [63:0] bm(input logic [7:0] s);
    logic [63:0] m = '0;
    for (int i = 0; i < 8; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Byte-by-byte reference: each accessed byte lands in whichever bus word holds it.
  function automatic exp_t model(input int k, input acc_t a);
    exp_t e;
    int xl = (k == 2) ? 32 : 64;
    int nb = (k == 2) ? 4 : 8;
    bit mis = (k != 1);
    int s = 1 << a.size;
    logic [63:0] am = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    logic [63:0] base, ba, m = '0;
    bit split = 0;
    e.ta = (xl == 32 && a.size == 3) || ((a.addr % s) != 0 && (!mis || s > nb));
    base = (a.addr & am) - ((a.addr & am) % nb);
    e.baddr[0] = base; e.baddr[1] = (base + nb) & am;
    e.strb[0] = '0; e.strb[1] = '0; e.wd[0] = '0; e.wd[1] = '0;
    for (int i = 0; i < s; i++) begin
      int bi, lane;
      ba = (a.addr + i) & am;
      bi = ((ba - (ba % nb)) == base) ? 0 : 1;
      lane = int'(ba % nb);
      if (bi == 1) split = 1;
      e.strb[bi][lane] = 1'b1;
      e.wd[bi][8*lane +: 8] = a.wdata[8*i +: 8];
      m[8*i +: 8] = (bi == 1) ? a.rd1[8*lane +: 8] : a.rd0[8*lane +: 8];
    end
    e.nbeats = e.ta ? 0 : ((split && !a.err0) ? 2 : 1);
    e.tb = !e.ta && (a.err0 || (split && a.err1));
    e.rdata = '0;
    if (a.load && !e.ta && !e.tb) begin
      e.rdata = m;
      if (8*s < xl && a.sext && m[8*s-1])
        for (int i = 8*s; i < xl; i++) e.rdata[i] = 1'b1;
      e.rdata = e.rdata & am;
    end
    return e;
  endfunction

  task automatic run(input int k, input acc_t a, output res_t r);
    exp_t e;
    int beat = 0, st = 0, ecyc;
    bit done = 0;
    e = model(k, a);
    ecyc = e.ta ? 1 : e.nbeats * (a.stall + 1) + 1;
    r.rdata = '0; r.tb = 0; r.ta = 0; r.s0 = '0; r.s1 = '0; r.cyc = 0;
    @(negedge g_clk);
    chk("ready_idle", o_ready[k], 1'b1);
    v[k] = 1'b1; i_addr = a.addr; i_wdata = a.wdata; i_load = a.load; i_store = !a.load;
    i_size = 2'(a.size); i_sext = a.sext;
    @(negedge g_clk);
    v[k] = 1'b0; i_addr = {$urandom, $urandom}; i_wdata = {$urandom, $urandom};
    i_size = 2'($urandom); i_sext = 1'($urandom); i_load = 1'($urandom); i_store = !i_load;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      g[k] = 1'b0; i_err = 1'b0; i_rdata = {$urandom, $urandom};
      if (o_rv[k]) begin
        done = 1; r.cyc = cyc; r.rdata = o_rdata[k]; r.tb = o_tb[k]; r.ta = o_ta[k];
        chk("rsp_rdata", o_rdata[k], e.rdata);
        chk("rsp_trap_bus", o_tb[k], e.tb);
        chk("rsp_trap_addr", o_ta[k], e.ta);
        chk("rsp_latency", 64'(cyc), 64'(ecyc));
        chk("beats_issued", 64'(beat), 64'(e.nbeats));
        chk("req_in_resp", o_req[k], 1'b0);
      end else begin
        chk("ready_busy", o_ready[k], 1'b0);
        if (o_req[k]) begin
          if (beat >= e.nbeats) chk("extra_beat", 64'(beat + 1), 64'(e.nbeats));
          else begin
            chk("beat_addr", o_addr[k], e.baddr[beat]);
            chk("beat_strb", o_strb[k], e.strb[beat]);
            chk("beat_wen", o_wen[k], !a.load);
            chk("beat_wdata", o_wdata[k] & bm(o_strb[k]), e.wd[beat]);
            if (beat == 0) r.s0 = o_strb[k]; else r.s1 = o_strb[k];
            if (st < a.stall) st++;
            else begin
              g[k] = 1'b1; st = 0;
              i_err = (beat == 0) ? a.err0 : a.err1;
              i_rdata = (beat == 0) ? a.rd0 : a.rd1;
              beat++;
            end
          end
        end else begin
          g[k] = 1'($urandom); i_err = 1'($urandom);
        end
        @(negedge g_clk);
      end
    end
    g[k] = 1'b0; i_err = 1'b0;
    if (!done) chk("rsp_timeout", 64'd0, 64'd1);
    @(negedge g_clk);
    chk("rsp_one_cycle", o_rv[k], 1'b0);
    chk("ready_after_rsp", o_ready[k], 1'b1);
  endtask

  task automatic add(input int k, input logic [63:0] addr, wdata, input bit load, input int size,
                     input bit sext, input int stall, input bit e0, e1, input logic [63:0] rd0, rd1,
                     input logic [63:0] rdata, input bit tb, ta, input logic [7:0] s0, s1, input int cyc);
    vec_t t;
    t.k = k; t.a.addr = addr; t.a.wdata = wdata; t.a.load = load; t.a.size = size; t.a.sext = sext;
    t.a.stall = stall; t.a.err0 = e0; t.a.err1 = e1; t.a.rd0 = rd0; t.a.rd1 = rd1;
    t.rdata = rdata; t.tb = tb; t.ta = ta; t.s0 = s0; t.s1 = s1; t.cyc = cyc;
    tbl.push_back(t);
  endtask

  initial begin
    res_t r;
    acc_t a;
    for (int i = 0; i < 3; i++) begin v[i] = 1'b0; g[i] = 1'b0; end
    i_addr = '0; i_wdata = '0; i_rdata = '0; i_load = 1'b1; i_store = 1'b0; i_sext = 1'b0;
    i_err = 1'b0; i_size = '0;

    //  k addr                   wdata                  ld sz sx st e0 e1 rd0                    rd1                    rdata                  tb ta s0     s1     cyc
    add(0, 64'h1004,             64'h0,                 1, 2, 1, 0, 0, 0, 64'h8000_0001_0000_0000, 64'h0,              64'hFFFF_FFFF_8000_0001, 0, 0, 8'hF0, 8'h00, 2);
    add(0, 64'h1006,             64'hAABB_CCDD,         0, 2, 0, 0, 0, 0, 64'h0,                 64'h0,                 64'h0,                 0, 0, 8'hC0, 8'h03, 3);
    add(1, 64'h2001,             64'h0,                 1, 1, 0, 0, 0, 0, 64'h0,                 64'h0,                 64'h0,                 0, 1, 8'h00, 8'h00, 1);
    add(0, 64'h1003,             64'h0,                 1, 3, 0, 0, 1, 0, 64'h1111_2222_3333_4444, 64'h5555,           64'h0,                 1, 0, 8'hF8, 8'h00, 2);
    add(2, 64'h3,                64'h0,                 1, 1, 0, 2, 0, 0, 64'h1234_5678,         64'h9ABC_DE34,         64'h3412,              0, 0, 8'h08, 8'h01, 7);
    add(0, 64'h1007,             64'h0,                 1, 0, 1, 0, 0, 0, 64'h80AA_0000_0000_0000, 64'h0,              64'hFFFF_FFFF_FFFF_FF80, 0, 0, 8'h80, 8'h00, 2);
    add(0, 64'h2000,             64'h0,                 1, 3, 1, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 64'h0,              64'h0123_4567_89AB_CDEF, 0, 0, 8'hFF, 8'h00, 2);
    add(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,              1, 1, 0, 0, 0, 0, 64'hAB00_0000_0000_0000, 64'hCD,             64'hCDAB,              0, 0, 8'h80, 8'h01, 3);
    add(2, 64'h10,               64'h1234,              0, 3, 0, 0, 0, 0, 64'h0,                 64'h0,                 64'h0,                 0, 1, 8'h00, 8'h00, 1);
    add(0, 64'h1006,             64'h0,                 1, 2, 1, 0, 0, 1, 64'hFFFF_0000_0000_0000, 64'hFFFF,           64'h0,                 1, 0, 8'hC0, 8'h03, 3);
    add(1, 64'h2008,             64'h0,                 1, 2, 0, 0, 0, 0, 64'h8765_4321,         64'h0,                 64'h8765_4321,         0, 0, 8'h0F, 8'h00, 2);
    add(2, 64'h1,                64'h0,                 1, 0, 1, 0, 0, 0, 64'hFF00,              64'h0,                 64'hFFFF_FFFF,         0, 0, 8'h02, 8'h00, 2);
    add(0, 64'h1006,             64'h0,                 1, 1, 1, 1, 0, 0, 64'h7FFF_0000_0000_0000, 64'h0,              64'h7FFF,              0, 0, 8'hC0, 8'h00, 3);
    add(0, 64'h1001,             64'h1122_3344_5566_7788, 0, 3, 0, 0, 0, 0, 64'h0,               64'h0,                 64'h0,                 0, 0, 8'hFE, 8'h01, 3);

    repeat (3) @(negedge g_clk);
    g_rst = 1'b0;
    @(negedge g_clk);
    chk("rst_ready", o_ready[0], 1'b1);   chk("rst_rsp_valid", o_rv[0], 1'b0);
    chk("rst_rdata", o_rdata[0], 64'h0);  chk("rst_traps", {o_tb[0], o_ta[0]}, 2'b00);
    chk("rst_req", o_req[0], 1'b0);       chk("rst_wen", o_wen[0], 1'b0);
    chk("rst_strb", o_strb[0], 8'h0);     chk("rst_addr", o_addr[0], 64'h0);
    chk("rst_wdata", o_wdata[0], 64'h0);  chk("rst_ready2", o_ready[2], 1'b1);

    foreach (tbl[i]) begin
      run(tbl[i].k, tbl[i].a, r);
      chk($sformatf("vec%0d_rdata", i), r.rdata, tbl[i].rdata);
      chk($sformatf("vec%0d_traps", i), {r.tb, r.ta}, {tbl[i].tb, tbl[i].ta});
      chk($sformatf("vec%0d_strb", i), {r.s0, r.s1}, {tbl[i].s0, tbl[i].s1});
      chk($sformatf("vec%0d_cycles", i), 64'(r.cyc), 64'(tbl[i].cyc));
    end

    // Reset while beat 1 is waiting on its grant.
    @(negedge g_clk);
    v[0] = 1'b1; i_addr = 64'h1006; i_load = 1'b1; i_store = 1'b0; i_size = 2'd2; i_sext = 1'b0;
    @(negedge g_clk);
    v[0] = 1'b0;
    chk("mid_beat0_req", o_req[0], 1'b1);
    g[0] = 1'b1; i_rdata = 64'h1;
    @(negedge g_clk);
    g[0] = 1'b0;
    chk("mid_beat1_req", o_req[0], 1'b1);
    chk("mid_beat1_addr", o_addr[0], 64'h1008);
    @(negedge g_clk);
    chk("mid_beat1_hold", o_req[0], 1'b1);
    g_rst = 1'b1;
    @(negedge g_clk);
    g_rst = 1'b0;
    chk("mid_rst_req", o_req[0], 1'b0);
    chk("mid_rst_ready", o_ready[0], 1'b1);
    chk("mid_rst_rsp", o_rv[0], 1'b0);
    g[0] = 1'b1; i_err = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge g_clk);
      chk("late_gnt_rsp", o_rv[0], 1'b0);
      chk("late_gnt_req", o_req[0], 1'b0);
    end
    g[0] = 1'b0; i_err = 1'b0;
    a.addr = 64'h1005; a.wdata = '0; a.load = 1; a.size = 0; a.sext = 1; a.stall = 0;
    a.err0 = 0; a.err1 = 0; a.rd0 = 64'h0000_4200_0000_0000; a.rd1 = '0;
    run(0, a, r);
    chk("post_rst_lb", r.rdata, 64'h42);

    for (int n = 0; n < 400; n++) begin
      int k = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       a.addr = 64'h1000 + 64'($urandom_range(0, 31));
        1:       a.addr = {$urandom, $urandom};
        2:       a.addr = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 15));
        default: a.addr = 64'h8000_0000 + 64'($urandom_range(0, 15));
      endcase
      if (k == 2) a.addr = a.addr & 64'hFFFF_FFFF;
      a.wdata = {$urandom, $urandom}; a.load = 1'($urandom); a.size = $urandom_range(0, 3);
      a.sext = 1'($urandom); a.stall = $urandom_range(0, 2);
      a.err0 = ($urandom_range(0, 9) == 0); a.err1 = ($urandom_range(0, 9) == 0);
      a.rd0 = {$urandom, $urandom}; a.rd1 = {$urandom, $urandom};
      run(k, a, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
